// File: rtl/arm_dp_pkg.sv
// Shared definitions for the ARM data-processing control path: sequencer
// states, condition codes, DP opcodes, ALU OP codes and decode helpers.
package arm_dp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } seq_state_e;

   // Bit positions inside the 4-bit NZCV register
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Condition field encodings (instr[31:28])
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Data-processing opcode field (instr[24:21])
   localparam logic [3:0] DP_AND = 4'h0;
   localparam logic [3:0] DP_EOR = 4'h1;
   localparam logic [3:0] DP_SUB = 4'h2;
   localparam logic [3:0] DP_RSB = 4'h3;
   localparam logic [3:0] DP_ADD = 4'h4;
   localparam logic [3:0] DP_ADC = 4'h5;
   localparam logic [3:0] DP_SBC = 4'h6;
   localparam logic [3:0] DP_RSC = 4'h7;
   localparam logic [3:0] DP_TST = 4'h8;
   localparam logic [3:0] DP_TEQ = 4'h9;
   localparam logic [3:0] DP_CMP = 4'hA;
   localparam logic [3:0] DP_CMN = 4'hB;
   localparam logic [3:0] DP_ORR = 4'hC;
   localparam logic [3:0] DP_MOV = 4'hD;
   localparam logic [3:0] DP_BIC = 4'hE;
   localparam logic [3:0] DP_MVN = 4'hF;

   // ALU OP codes, shared with the ALU
   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_EOR = 5'b00001;
   localparam logic [4:0] ALU_SUB = 5'b00010;
   localparam logic [4:0] ALU_RSB = 5'b00011;
   localparam logic [4:0] ALU_ADD = 5'b00100;
   localparam logic [4:0] ALU_ADC = 5'b00101;
   localparam logic [4:0] ALU_SBC = 5'b00110;
   localparam logic [4:0] ALU_RSC = 5'b00111;
   localparam logic [4:0] ALU_TST = 5'b01000;
   localparam logic [4:0] ALU_TEQ = 5'b01001;
   localparam logic [4:0] ALU_CMP = 5'b01010;
   localparam logic [4:0] ALU_CMN = 5'b01011;
   localparam logic [4:0] ALU_ORR = 5'b01100;
   localparam logic [4:0] ALU_MOV = 5'b10000;  // B-operand bypass
   localparam logic [4:0] ALU_BIC = 5'b01110;
   localparam logic [4:0] ALU_MVN = 5'b01111;

   // Map the 4-bit DP opcode onto the 5-bit ALU OP code
   function automatic logic [4:0] dp_to_alu_op(input logic [3:0] opc);
      logic [4:0] op;
      case (opc)
         DP_AND:  op = ALU_AND;
         DP_EOR:  op = ALU_EOR;
         DP_SUB:  op = ALU_SUB;
         DP_RSB:  op = ALU_RSB;
         DP_ADD:  op = ALU_ADD;
         DP_ADC:  op = ALU_ADC;
         DP_SBC:  op = ALU_SBC;
         DP_RSC:  op = ALU_RSC;
         DP_TST:  op = ALU_TST;
         DP_TEQ:  op = ALU_TEQ;
         DP_CMP:  op = ALU_CMP;
         DP_CMN:  op = ALU_CMN;
         DP_ORR:  op = ALU_ORR;
         DP_MOV:  op = ALU_MOV;
         DP_BIC:  op = ALU_BIC;
         default: op = ALU_MVN;
      endcase
      return op;
   endfunction

   // Test/compare opcodes only produce flags: S forced, no register write
   function automatic logic is_compare(input logic [3:0] opc);
      return (opc == DP_TST) || (opc == DP_TEQ) || (opc == DP_CMP) || (opc == DP_CMN);
   endfunction

   // 8-bit immediate rotated right by twice the 4-bit rotate field
   function automatic logic [31:0] rot_imm(input logic [11:0] field);
      logic [63:0] dbl;
      dbl = {24'h0, field[7:0], 24'h0, field[7:0]} >> {field[11:8], 1'b0};
      return dbl[31:0];
   endfunction

endpackage

// File: rtl/arm_cond_eval.sv
// Combinational ARM condition-code check against the stored NZCV flags.
module arm_cond_eval
   import arm_dp_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = flags[FLAG_N];
   assign w_z = flags[FLAG_Z];
   assign w_c = flags[FLAG_C];
   assign w_v = flags[FLAG_V];

   // Decide whether the instruction executes under the current flags
   always_comb begin
      // NOTE: default assignment first so no path leaves pass unassigned, which would infer a latch.
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = ~w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = ~w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = ~w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = ~w_v;
         COND_HI: pass = w_c & ~w_z;
         COND_LS: pass = ~w_c | w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = ~w_z & (w_n == w_v);
         COND_LE: pass = w_z | (w_n != w_v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_dp_sequencer.sv
// Four-state control sequencer for ARM data-processing instructions:
// accept -> decode/condition check -> ALU execute -> register/flag writeback.
module arm_dp_sequencer
   import arm_dp_pkg::*;
#(
   parameter bit         IMM_EN    = 1'b1,
   parameter logic [3:0] FLAGS_RST = 4'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   output logic [3:0]  rf_raddr_a,
   output logic [3:0]  rf_raddr_b,
   output logic        op2_sel,
   output logic [31:0] op2_imm,
   output logic [4:0]  alu_op,
   output logic        alu_s,
   output logic        alu_out_en,
   output logic [3:0]  flags,
   input  logic [3:0]  alu_flags_in,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic        done,
   output logic        skipped,
   output logic        illegal
);

   seq_state_e  r_state;
   logic        r_instr_ready;
   logic [3:0]  r_flags;
   logic        r_done;
   logic        r_skipped;
   logic        r_illegal;
   logic        r_rf_we;
   logic [3:0]  r_rf_waddr;
   logic        r_alu_out_en;

   // Only the IR fields still needed after the decode cycle are kept
   logic [3:0]  r_ir_opc;
   logic [3:0]  r_ir_rd;

   logic [3:0]  r_raddr_a;
   logic [3:0]  r_raddr_b;
   logic        r_op2_sel;
   logic [31:0] r_op2_imm;
   logic [4:0]  r_alu_op;
   logic        r_alu_s;

   logic        w_accept;
   logic        w_release;
   logic        w_cond_pass;
   logic        w_illegal;
   logic        w_imm;

   // The condition is evaluated on the incoming word at acceptance: flags
   // only change at the end of WB, so they are identical in the DECODE
   // cycle, and this lets done/skipped/illegal leave a register in cycle 1.
   arm_cond_eval u_cond_eval (
      .cond  (instr[31:28]),
      .flags (r_flags),
      .pass  (w_cond_pass)
   );

   assign w_imm     = instr[25] & IMM_EN;
   assign w_illegal = (instr[27:26] != 2'b00) | (instr[25] & ~IMM_EN);
   assign w_accept  = (r_state == ST_IDLE) & instr_valid;
   assign w_release = ((r_state == ST_DECODE) & (r_skipped | r_illegal)) | (r_state == ST_WB);

   // Control FSM: state, handshake, retire pulses, write strobe and flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_instr_ready <= 1'b1;
         r_flags       <= FLAGS_RST;
         r_done        <= 1'b0;
         r_skipped     <= 1'b0;
         r_illegal     <= 1'b0;
         r_rf_we       <= 1'b0;
         r_rf_waddr    <= 4'h0;
         r_alu_out_en  <= 1'b0;
         r_ir_opc      <= 4'h0;
         r_ir_rd       <= 4'h0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         r_done    <= 1'b0;
         r_skipped <= 1'b0;
         r_illegal <= 1'b0;
         r_rf_we   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  r_ir_opc      <= instr[24:21];
                  r_ir_rd       <= instr[15:12];
                  r_instr_ready <= 1'b0;
                  r_state       <= ST_DECODE;
                  if (w_illegal) begin
                     r_done    <= 1'b1;
                     r_illegal <= 1'b1;
                  end else if (!w_cond_pass) begin
                     r_done    <= 1'b1;
                     r_skipped <= 1'b1;
                  end
               end
            end
            ST_DECODE: begin
               if (r_skipped || r_illegal) begin
                  r_state       <= ST_IDLE;
                  r_instr_ready <= 1'b1;
               end else begin
                  r_state      <= ST_EXEC;
                  r_alu_out_en <= 1'b1;
               end
            end
            ST_EXEC: begin
               r_state    <= ST_WB;
               r_done     <= 1'b1;
               r_rf_we    <= ~is_compare(r_ir_opc);
               r_rf_waddr <= r_ir_rd;
            end
            ST_WB: begin
               if (r_alu_s) begin
                  r_flags <= alu_flags_in;
               end
               r_state       <= ST_IDLE;
               r_instr_ready <= 1'b1;
               r_alu_out_en  <= 1'b0;
               r_rf_waddr    <= 4'h0;
            end
            default: begin
               r_state       <= ST_IDLE;
               r_instr_ready <= 1'b1;
               r_alu_out_en  <= 1'b0;
               r_rf_waddr    <= 4'h0;
            end
         endcase
      end
   end

   // Decoded operand controls: loaded on acceptance, held until retire, then zeroed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_raddr_a <= 4'h0;
         r_raddr_b <= 4'h0;
         r_op2_sel <= 1'b0;
         r_op2_imm <= 32'h0;
         r_alu_op  <= 5'h0;
         r_alu_s   <= 1'b0;
      end else if (w_accept) begin
         r_raddr_a <= instr[19:16];
         r_raddr_b <= instr[3:0];
         r_op2_sel <= w_imm;
         r_op2_imm <= w_imm ? rot_imm(instr[11:0]) : 32'h0;
         r_alu_op  <= dp_to_alu_op(instr[24:21]);
         r_alu_s   <= instr[20] | is_compare(instr[24:21]);
      end else if (w_release) begin
         r_raddr_a <= 4'h0;
         r_raddr_b <= 4'h0;
         r_op2_sel <= 1'b0;
         r_op2_imm <= 32'h0;
         r_alu_op  <= 5'h0;
         r_alu_s   <= 1'b0;
      end
   end

   assign instr_ready = r_instr_ready;
   assign rf_raddr_a  = r_raddr_a;
   assign rf_raddr_b  = r_raddr_b;
   assign op2_sel     = r_op2_sel;
   assign op2_imm     = r_op2_imm;
   assign alu_op      = r_alu_op;
   assign alu_s       = r_alu_s;
   assign alu_out_en  = r_alu_out_en;
   assign flags       = r_flags;
   assign rf_we       = r_rf_we;
   assign rf_waddr    = r_rf_waddr;
   assign done        = r_done;
   assign skipped     = r_skipped;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Self-checking bench for arm_dp_sequencer. Main instance uses defaults;
// a second instance has IMM_EN=0 and a non-zero FLAGS_RST.
module tb_arm_dp_sequencer;

   typedef struct packed {
      logic       skipped;
      logic       illegal;
      logic       we;
      logic [3:0] waddr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = 32'h0;
   logic [3:0]  alu_flags_in = 4'h0;
   logic        instr_ready;
   logic [3:0]  rf_raddr_a, rf_raddr_b, flags, rf_waddr;
   logic        op2_sel, alu_s, alu_out_en, rf_we, done, skipped, illegal;
   logic [31:0] op2_imm;
   logic [4:0]  alu_op;

   logic        d2_instr_valid = 1'b0;
   logic [31:0] d2_instr = 32'h0;
   logic        d2_instr_ready;
   logic [3:0]  d2_rf_raddr_a, d2_rf_raddr_b, d2_flags, d2_rf_waddr;
   logic        d2_op2_sel, d2_alu_s, d2_alu_out_en, d2_rf_we, d2_done, d2_skipped, d2_illegal;
   logic [31:0] d2_op2_imm;
   logic [4:0]  d2_alu_op;

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];
   exp_t mon_exp;
   exp_t mon_got;

   always #5 clk = ~clk;

   arm_dp_sequencer dut (
      .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .op2_sel(op2_sel),
      .op2_imm(op2_imm), .alu_op(alu_op), .alu_s(alu_s), .alu_out_en(alu_out_en),
      .flags(flags), .alu_flags_in(alu_flags_in), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .done(done), .skipped(skipped), .illegal(illegal)
   );

   arm_dp_sequencer #(.IMM_EN(1'b0), .FLAGS_RST(4'b0100)) dut2 (
      .clk(clk), .reset_n(reset_n), .instr_valid(d2_instr_valid), .instr_ready(d2_instr_ready),
      .instr(d2_instr), .rf_raddr_a(d2_rf_raddr_a), .rf_raddr_b(d2_rf_raddr_b), .op2_sel(d2_op2_sel),
      .op2_imm(d2_op2_imm), .alu_op(d2_alu_op), .alu_s(d2_alu_s), .alu_out_en(d2_alu_out_en),
      .flags(d2_flags), .alu_flags_in(4'h0), .rf_we(d2_rf_we), .rf_waddr(d2_rf_waddr),
      .done(d2_done), .skipped(d2_skipped), .illegal(d2_illegal)
   );

   // Scoreboard: every retire on the main instance must match the oldest expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL retire_unexpected: got done with no queued expectation");
         end else begin
            mon_exp = sb_q.pop_front();
            mon_got = '{skipped: skipped, illegal: illegal, we: rf_we, waddr: rf_waddr};
            if (mon_got !== mon_exp) begin
               bad++;
               $display("FAIL retire_fields: got skip/ill/we/waddr=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                        mon_got.skipped, mon_got.illegal, mon_got.we, mon_got.waddr,
                        mon_exp.skipped, mon_exp.illegal, mon_exp.we, mon_exp.waddr);
            end
         end
      end else if (rf_we !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL rf_we_without_done: got rf_we=%b expected 0", rf_we);
      end
   end

   // Reference condition model built from the base test plus invert bit
   function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? ~base : base;
   endfunction

   // Every DP opcode maps to {0,opcode} except MOV, which is the bypass code
   function automatic logic [4:0] exp_alu_op(input logic [3:0] o);
      return (o == 4'hD) ? 5'b10000 : {1'b0, o};
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (instr_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got instr_ready=%b expected 1 within 20 cycles", instr_ready);
      end
   endtask

   // Offer one word; returns just after the accepting edge (start of cycle 1)
   task automatic send(input logic [31:0] w);
      wait_ready();
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b expected 0000", flags); end
      total++; if ({done, rf_we, alu_out_en, op2_sel} !== 4'b0) begin bad++; $display("FAIL reset_ctrl: got %b expected 0000", {done, rf_we, alu_out_en, op2_sel}); end
      total++; if ({alu_op, op2_imm} !== 37'h0) begin bad++; $display("FAIL reset_fields: got op=%b imm=%h expected 0", alu_op, op2_imm); end
      total++; if (d2_flags !== 4'b0100) begin bad++; $display("FAIL reset_flags_param: got %b expected 0100", d2_flags); end
      reset_n = 1'b1;
   endtask

   task automatic test_moveq_skip();
      sb_q.push_back('{skipped: 1'b1, illegal: 1'b0, we: 1'b0, waddr: 4'h0});
      send(32'h01A01002);
      @(negedge clk);
      total++; if ({done, skipped, illegal} !== 3'b110) begin bad++; $display("FAIL moveq_skip_c1: got done/skip/ill=%b expected 110", {done, skipped, illegal}); end
      @(negedge clk);
      total++; if ({instr_ready, alu_out_en} !== 2'b10) begin bad++; $display("FAIL moveq_skip_c2: got ready/out_en=%b expected 10", {instr_ready, alu_out_en}); end
      total++; if (flags !== 4'h0) begin bad++; $display("FAIL moveq_skip_flags: got %b expected 0000", flags); end
   endtask

   task automatic test_adds();
      alu_flags_in = 4'b0110;
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b1, waddr: 4'd1});
      send(32'hE0921003);
      @(negedge clk);
      total++; if ({rf_raddr_a, rf_raddr_b} !== 8'h23) begin bad++; $display("FAIL adds_raddr: got a=%0d b=%0d expected 2,3", rf_raddr_a, rf_raddr_b); end
      total++; if ({done, op2_sel} !== 2'b00) begin bad++; $display("FAIL adds_c1_ctrl: got done/op2_sel=%b expected 00", {done, op2_sel}); end
      @(negedge clk);
      total++; if ({alu_op, alu_s, alu_out_en} !== 7'b0010011) begin bad++; $display("FAIL adds_exec: got op=%b s=%b en=%b expected 00100 1 1", alu_op, alu_s, alu_out_en); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL adds_exec_we: got %b expected 0", rf_we); end
      @(negedge clk);
      total++; if ({rf_we, rf_waddr, done, alu_out_en} !== 7'b1000111) begin bad++; $display("FAIL adds_wb: got we=%b waddr=%0d done=%b en=%b expected 1 1 1 1", rf_we, rf_waddr, done, alu_out_en); end
      @(negedge clk);
      total++; if (flags !== 4'b0110) begin bad++; $display("FAIL adds_flags: got %b expected 0110", flags); end
      total++; if ({instr_ready, alu_op, alu_out_en} !== 7'b1000000) begin bad++; $display("FAIL adds_idle: got ready=%b op=%b en=%b expected 1 00000 0", instr_ready, alu_op, alu_out_en); end
   endtask

   task automatic test_moveq_exec();
      alu_flags_in = 4'b1111;
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b1, waddr: 4'd1});
      send(32'h01A01002);
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL moveq_exec_c1: got done=%b expected 0", done); end
      @(negedge clk);
      total++; if ({alu_op, alu_s} !== 6'b100000) begin bad++; $display("FAIL moveq_exec_op: got op=%b s=%b expected 10000 0", alu_op, alu_s); end
      repeat (2) @(negedge clk);
      total++; if (flags !== 4'b0110) begin bad++; $display("FAIL moveq_flags_kept: got %b expected 0110", flags); end
   endtask

   task automatic test_cmp();
      alu_flags_in = 4'b0100;
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b0, waddr: 4'd0});
      send(32'hE1520003);
      repeat (2) @(negedge clk);
      total++; if ({alu_op, alu_s} !== 6'b010101) begin bad++; $display("FAIL cmp_op: got op=%b s=%b expected 01010 1", alu_op, alu_s); end
      repeat (2) @(negedge clk);
      total++; if (flags !== 4'b0100) begin bad++; $display("FAIL cmp_flags: got %b expected 0100", flags); end
   endtask

   task automatic test_mov_imm();
      logic [31:0] words [3];
      logic [31:0] imms [3];
      logic [3:0]  rds [3];
      words[0] = 32'hE3A004FF; imms[0] = 32'hFF000000; rds[0] = 4'd0;
      words[1] = 32'hE3A0305A; imms[1] = 32'h0000005A; rds[1] = 4'd3;
      words[2] = 32'hE3A05103; imms[2] = 32'hC0000000; rds[2] = 4'd5;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b1, waddr: rds[i]});
         send(words[i]);
         @(negedge clk);
         total++; if ({op2_sel, op2_imm} !== {1'b1, imms[i]}) begin bad++; $display("FAIL imm_%0d_c1: got sel=%b imm=%h expected 1 %h", i, op2_sel, op2_imm, imms[i]); end
         @(negedge clk);
         total++; if ({alu_op, op2_imm} !== {5'b10000, imms[i]}) begin bad++; $display("FAIL imm_%0d_exec: got op=%b imm=%h expected 10000 %h", i, alu_op, op2_imm, imms[i]); end
      end
   endtask

   task automatic test_imm_disabled();
      @(negedge clk);
      d2_instr = 32'hE3A004FF;
      d2_instr_valid = 1'b1;
      @(posedge clk);
      #1 d2_instr_valid = 1'b0;
      @(negedge clk);
      total++; if ({d2_done, d2_illegal, d2_skipped, d2_op2_sel} !== 4'b1100) begin bad++; $display("FAIL immdis_illegal: got done/ill/skip/sel=%b expected 1100", {d2_done, d2_illegal, d2_skipped, d2_op2_sel}); end
      @(negedge clk);
      total++; if ({d2_instr_ready, d2_done} !== 2'b10) begin bad++; $display("FAIL immdis_ready: got ready/done=%b expected 10", {d2_instr_ready, d2_done}); end
      // Z=1 from the reset flag value lets MOVEQ execute
      d2_instr = 32'h01A01002;
      d2_instr_valid = 1'b1;
      @(posedge clk);
      #1 d2_instr_valid = 1'b0;
      @(negedge clk);
      total++; if (d2_done !== 1'b0) begin bad++; $display("FAIL immdis_moveq_c1: got done=%b expected 0", d2_done); end
      @(negedge clk);
      total++; if (d2_alu_op !== 5'b10000) begin bad++; $display("FAIL immdis_moveq_op: got %b expected 10000", d2_alu_op); end
      @(negedge clk);
      total++; if ({d2_rf_we, d2_rf_waddr} !== 5'b10001) begin bad++; $display("FAIL immdis_moveq_wb: got we=%b waddr=%0d expected 1 1", d2_rf_we, d2_rf_waddr); end
   endtask

   task automatic test_opcodes();
      logic [3:0]  opc;
      logic        cmpop;
      alu_flags_in = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         opc = 4'(i);
         cmpop = (opc[3:2] == 2'b10);
         sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: ~cmpop, waddr: opc});
         send({4'hE, 3'b000, opc, 1'b0, 4'h2, opc, 12'h003});
         repeat (2) @(negedge clk);
         total++; if ({alu_op, alu_s} !== {exp_alu_op(opc), cmpop}) begin bad++; $display("FAIL opcode_%0d: got op=%b s=%b expected %b %b", i, alu_op, alu_s, exp_alu_op(opc), cmpop); end
      end
   endtask

   task automatic test_cond_codes();
      logic [3:0] pats [5];
      logic       pass;
      pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1001; pats[3] = 4'b0010; pats[4] = 4'b1011;
      for (int p = 0; p < 5; p++) begin
         alu_flags_in = pats[p];
         sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b0, waddr: 4'h0});
         send(32'hE1500000);
         wait_ready();
         total++; if (flags !== pats[p]) begin bad++; $display("FAIL cond_setup_%0d: got flags=%b expected %b", p, flags, pats[p]); end
         for (int c = 0; c < 16; c++) begin
            pass = exp_cond(4'(c), pats[p]);
            sb_q.push_back('{skipped: ~pass, illegal: 1'b0, we: 1'b0, waddr: 4'h0});
            send({4'(c), 28'h1500000});
            @(negedge clk);
            total++; if ({done, skipped} !== {~pass, ~pass}) begin bad++; $display("FAIL cond_%0d_flags_%b: got done/skip=%b%b expected %b%b", c, pats[p], done, skipped, ~pass, ~pass); end
         end
      end
   endtask

   task automatic test_back_to_back();
      alu_flags_in = 4'b1010;
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b1, waddr: 4'd1});
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b1, waddr: 4'd4});
      wait_ready();
      instr = 32'hE0921003;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr = 32'hE0454006;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         total++; if ({instr_ready, rf_raddr_a} !== 5'b00010) begin bad++; $display("FAIL b2b_hold_c%0d: got ready=%b raddr_a=%0d expected 0 2", cyc, instr_ready, rf_raddr_a); end
      end
      @(negedge clk);
      total++; if ({instr_ready, rf_raddr_a} !== 5'b10000) begin bad++; $display("FAIL b2b_ready_c4: got ready=%b raddr_a=%0d expected 1 0", instr_ready, rf_raddr_a); end
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      total++; if ({rf_raddr_a, rf_raddr_b, alu_op} !== {4'd5, 4'd6, 5'b00010}) begin bad++; $display("FAIL b2b_second: got a=%0d b=%0d op=%b expected 5 6 00010", rf_raddr_a, rf_raddr_b, alu_op); end
      wait_ready();
      total++; if (flags !== 4'b1010) begin bad++; $display("FAIL b2b_flags: got %b expected 1010", flags); end
   endtask

   task automatic test_reset_mid_exec();
      alu_flags_in = 4'b0001;
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b0, we: 1'b1, waddr: 4'd1});
      send(32'hE0921003);
      repeat (2) @(negedge clk);
      total++; if (alu_out_en !== 1'b1) begin bad++; $display("FAIL rst_pre_exec: got alu_out_en=%b expected 1", alu_out_en); end
      #2 reset_n = 1'b0;
      #1;
      total++; if ({flags, instr_ready, rf_we, done, alu_out_en} !== 8'b0000_1000) begin bad++; $display("FAIL rst_async: got flags=%b ready=%b we=%b done=%b en=%b expected 0000 1 0 0 0", flags, instr_ready, rf_we, done, alu_out_en); end
      total++; if (alu_op !== 5'b0) begin bad++; $display("FAIL rst_async_op: got %b expected 00000", alu_op); end
      repeat (2) @(negedge clk);
      void'(sb_q.pop_back());
      reset_n = 1'b1;
      @(negedge clk);
      total++; if ({instr_ready, flags} !== 5'b10000) begin bad++; $display("FAIL rst_after: got ready=%b flags=%b expected 1 0000", instr_ready, flags); end
   endtask

   task automatic test_branch_illegal();
      sb_q.push_back('{skipped: 1'b0, illegal: 1'b1, we: 1'b0, waddr: 4'h0});
      send(32'hEA000000);
      @(negedge clk);
      total++; if ({done, illegal, skipped} !== 3'b110) begin bad++; $display("FAIL branch_illegal: got done/ill/skip=%b expected 110", {done, illegal, skipped}); end
      @(negedge clk);
      total++; if ({instr_ready, alu_out_en} !== 2'b10) begin bad++; $display("FAIL branch_idle: got ready/en=%b expected 10", {instr_ready, alu_out_en}); end
   endtask

   initial begin
      test_reset();
      test_moveq_skip();
      test_adds();
      test_moveq_exec();
      test_cmp();
      test_mov_imm();
      test_imm_disabled();
      test_opcodes();
      test_cond_codes();
      test_back_to_back();
      test_reset_mid_exec();
      test_branch_illegal();
      repeat (4) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending retires expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/arm_dp_sequencer.md
Name: arm_dp_sequencer

Overview:
Multi-cycle control sequencer that accepts one 32-bit ARM data-processing instruction at a time over a valid/ready handshake. It checks the condition field against the stored NZCV status register and decodes the opcode into the 5-bit ALU operation code. It drives the ALU's S and output-enable controls, then commits the result to the register file and latches the updated flags. It is the control-side counterpart of the ALU: it produces OP/S/ALU_OUT/FLAGS and consumes the ALU's FLAGS_OUT.

Parameters:
IMM_EN, 1, 1 = decode I-bit rotated immediates; 0 = treat I=1 instructions as illegal
FLAGS_RST, 4'h0, reset value of the NZCV register

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
instr  in  32  ARM instruction word
rf_raddr_a  out  4  Rn read address
rf_raddr_b  out  4  Rm read address
op2_sel  out  1  1 = ALU B operand from op2_imm
op2_imm  out  32  rotated immediate
alu_op  out  5  ALU OP code
alu_s  out  1  ALU S (flag update enable)
alu_out_en  out  1  ALU output enable (ALU_OUT)
flags  out  4  stored NZCV {N,Z,C,V} = bits [3:0], fed to ALU FLAGS
alu_flags_in  in  4  ALU FLAGS_OUT
rf_we  out  1  register-file write strobe
rf_waddr  out  4  Rd
done  out  1  one-cycle pulse: instruction retired
skipped  out  1  one-cycle pulse with done: condition failed
illegal  out  1  one-cycle pulse with done: not data-processing (instr[27:26] != 00) or I=1 with IMM_EN=0

Behaviour:
- Reset values: state IDLE, instr_ready=1, flags=FLAGS_RST, IR=0, all other outputs 0.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr into IR and go to DECODE. Any instr change while not ready is ignored.
- DECODE:
  - rf_raddr_a=IR[19:16], rf_raddr_b=IR[3:0].
  - Evaluate cond IR[31:28] against flags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
  - Illegal encoding -> done=1, illegal=1, back to IDLE.
  - Condition fail -> done=1, skipped=1, back to IDLE.
  - Otherwise go to EXEC.
- Opcode map IR[24:21] -> alu_op: AND 00000, EOR 00001, SUB 00010, RSB 00011, ADD 00100, ADC 00101, SBC 00110, RSC 00111, TST 01000, TEQ 01001, CMP 01010, CMN 01011, ORR 01100, MOV 10000 (bypass), BIC 01110, MVN 01111.
- alu_s = IR[20], forced to 1 for TST/TEQ/CMP/CMN.
- Immediate: op2_sel=IR[25]; op2_imm = ROR({24'h0, IR[7:0]}, 2*IR[11:8]); rotation of 0 gives the zero-extended value.
- EXEC: alu_op, alu_s, op2_* and read addresses held stable. alu_out_en=1 so the combinational ALU settles.
- WB:
  - alu_out_en=1; rf_waddr=IR[15:12].
  - rf_we=1 unless the opcode is TST/TEQ/CMP/CMN.
  - If alu_s, flags <= alu_flags_in at the end of WB; otherwise flags are unchanged.
  - done=1; next state IDLE.
- Latency: accepted in cycle 0 -> DECODE cycle 1 -> EXEC cycle 2 -> WB/done cycle 3 -> ready in cycle 4. Skipped or illegal instructions retire in cycle 1. Throughput is 1 instruction per 4 cycles, or 2 when skipped.
- alu_op, alu_s, op2_* and rf_raddr_* are registered from IR and held from DECODE through WB. In IDLE they return to 0.
- Flags written in WB are visible to the condition check of the next instruction.
- Asynchronous reset at any point, including mid-EXEC or WB: immediate return to reset values. No rf_we is generated for the aborted instruction, and flags return to FLAGS_RST.

Decomposition:
- Package arm_dp_pkg:
  - state enum
  - cond-code constants (EQ..NV)
  - ALU OP constants, shared with the ALU
  - flag bit indices N=3, Z=2, C=1, V=0
  - function mapping the 4-bit DP opcode to the 5-bit ALU OP
- Sub-module arm_cond_eval: combinational; inputs cond[3:0] and flags[3:0], output pass.

Test Plan:
- Reset: assert reset_n=0 mid-run -> flags=0, instr_ready=1, rf_we=0, done=0 immediately, asynchronously.
- ADDS R1,R2,R3 (0xE0921003), alu_flags_in=4'b0110:
  - cycle 1: rf_raddr_a=2, rf_raddr_b=3.
  - cycle 2: alu_op=00100, alu_s=1.
  - cycle 3: rf_we=1, rf_waddr=1, done=1.
  - then flags=0110; ready in cycle 4.
- CMP R2,R3 (0xE1520003), alu_flags_in=4'b0100 -> alu_op=01010, alu_s=1, rf_we never asserts, flags=0100 after WB.
- MOVEQ R1,R2 (0x01A01002) with flags Z=0 -> cycle 1: done=1, skipped=1; no EXEC, no rf_we, flags unchanged. Repeating with Z=1 -> alu_op=10000, rf_we=1, rf_waddr=1.
- MOV R0,#0xFF000000 (0xE3A004FF) -> op2_sel=1, op2_imm=32'hFF000000, alu_op=10000, rf_waddr=0. Repeating with IMM_EN=0 -> illegal=1 in cycle 1.
- Back-to-back: instr_valid held high with two instructions -> second is accepted only when instr_ready returns (cycle 4). A branch word 0xEA000000 -> illegal=1, done=1, no rf_we.
